// File: rtl/calc_result_disp_if.sv
// calc_result_disp_if: start/data request and registered display results of the calculator result stage
interface calc_result_disp_if #(parameter int WIDTH = 6);
  logic start;
  logic [WIDTH-1:0] data_in;
  logic busy;
  logic valid;
  logic neg;
  logic [3:0] tens_bcd;
  logic [3:0] ones_bcd;
  logic [6:0] sign_seg;
  logic [6:0] tens_seg;
  logic [6:0] ones_seg;
  modport master (
    output start, data_in,
    input busy, valid, neg, tens_bcd, ones_bcd, sign_seg, tens_seg, ones_seg
  );
  modport slave (
    input start, data_in,
    output busy, valid, neg, tens_bcd, ones_bcd, sign_seg, tens_seg, ones_seg
  );
endinterface

// File: rtl/calc_result_disp.sv
// calc_result_disp: converts a signed difference to sign + two BCD digits and 7-segment patterns
module calc_result_disp #(
  parameter int WIDTH = 6,
  parameter bit SEG_ACTIVE_LOW = 1
) (
  input logic clk,
  input logic rst,
  calc_result_disp_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ABS, DIV} state_t;
  localparam logic [6:0] BLANK = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [6:0] INV = {7{SEG_ACTIVE_LOW}};
  localparam logic [WIDTH:0] TEN = (WIDTH + 1)'(10);
  state_t state, next;
  logic [WIDTH-1:0] raw_r;
  logic [WIDTH:0] mag_r;
  logic [3:0] cnt_r;
  logic neg_r;
  logic done;
  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0: seg7 = 7'h3F;
      4'd1: seg7 = 7'h06;
      4'd2: seg7 = 7'h5B;
      4'd3: seg7 = 7'h4F;
      4'd4: seg7 = 7'h66;
      4'd5: seg7 = 7'h6D;
      4'd6: seg7 = 7'h7D;
      4'd7: seg7 = 7'h07;
      4'd8: seg7 = 7'h7F;
      4'd9: seg7 = 7'h6F;
      default: seg7 = 7'h00;
    endcase
  endfunction
  always_ff @(posedge clk)
    state <= rst ? IDLE : next;
  always_comb begin
    done = state == DIV && mag_r < TEN;
    next = state == IDLE ? (bus.start ? ABS : IDLE) : state == ABS ? DIV : done ? IDLE : DIV;
  end
  always_comb
    bus.busy = state != IDLE;
  // mag_r is one bit wider than the input so the most negative value and the constant 10 both fit
  always_ff @(posedge clk) begin
    if (rst) begin
      raw_r <= '0;
      neg_r <= 1'b0;
      mag_r <= '0;
      cnt_r <= '0;
    end else begin
      if (state == IDLE && bus.start) raw_r <= bus.data_in;
      if (state == ABS) begin
        neg_r <= raw_r[WIDTH-1];
        mag_r <= {1'b0, raw_r[WIDTH-1] ? ~raw_r + 1'b1 : raw_r};
        cnt_r <= '0;
      end
      if (state == DIV && !done) begin
        mag_r <= mag_r - TEN;
        cnt_r <= cnt_r + 4'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.valid <= 1'b0;
      bus.neg <= 1'b0;
      bus.tens_bcd <= '0;
      bus.ones_bcd <= '0;
      bus.sign_seg <= BLANK;
      bus.tens_seg <= BLANK;
      bus.ones_seg <= BLANK;
    end else begin
      bus.valid <= done;
      if (done) begin
        bus.neg <= neg_r;
        bus.tens_bcd <= cnt_r;
        bus.ones_bcd <= mag_r[3:0];
        bus.sign_seg <= neg_r ? 7'h40 ^ INV : BLANK;
        bus.tens_seg <= cnt_r == 4'd0 ? BLANK : seg7(cnt_r) ^ INV;
        bus.ones_seg <= seg7(mag_r[3:0]) ^ INV;
      end
    end
  end
endmodule

// File: tb/tb_calc_result_disp.sv
// tb_calc_result_disp: directed checks of the result display stage (6-bit and 4-bit builds)
module tb_calc_result_disp;
  logic clk = 1'b0;
  logic rst;
  int n_checks = 0;
  int n_fail = 0;
  calc_result_disp_if #(.WIDTH(6)) b6 ();
  calc_result_disp_if #(.WIDTH(4)) b4 ();
  calc_result_disp #(.WIDTH(6), .SEG_ACTIVE_LOW(1)) u6 (.clk(clk), .rst(rst), .bus(b6.slave));
  calc_result_disp #(.WIDTH(4), .SEG_ACTIVE_LOW(1)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_valid6(output int n);
    n = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (b6.valid === 1'b1) begin
        n = k;
        break;
      end
    end
  endtask
  task automatic launch6(input logic [5:0] d);
    b6.data_in = d;
    b6.start = 1'b1;
    tick();
    b6.start = 1'b0;
  endtask
  task automatic test_reset();
    n_checks += 7;
    if (b6.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", b6.busy); end
    if (b6.valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", b6.valid); end
    if (b6.neg !== 1'b0) begin n_fail++; $display("FAIL reset_neg got %b exp 0", b6.neg); end
    if ({b6.tens_bcd, b6.ones_bcd} !== 8'h00) begin n_fail++; $display("FAIL reset_bcd got %h exp 00", {b6.tens_bcd, b6.ones_bcd}); end
    if (b6.sign_seg !== 7'h7F) begin n_fail++; $display("FAIL reset_sign_seg got %h exp 7f", b6.sign_seg); end
    if (b6.tens_seg !== 7'h7F) begin n_fail++; $display("FAIL reset_tens_seg got %h exp 7f", b6.tens_seg); end
    if (b6.ones_seg !== 7'h7F) begin n_fail++; $display("FAIL reset_ones_seg got %h exp 7f", b6.ones_seg); end
  endtask
  task automatic test_neg15();
    int n;
    launch6(6'b110001);
    n_checks += 2;
    if (b6.busy !== 1'b1) begin n_fail++; $display("FAIL m15_busy got %b exp 1", b6.busy); end
    if (b6.valid !== 1'b0) begin n_fail++; $display("FAIL m15_early_valid got %b exp 0", b6.valid); end
    wait_valid6(n);
    n_checks += 7;
    if (n !== 3) begin n_fail++; $display("FAIL m15_latency got %0d exp 3", n); end
    if (b6.busy !== 1'b0) begin n_fail++; $display("FAIL m15_busy_fall got %b exp 0", b6.busy); end
    if (b6.neg !== 1'b1) begin n_fail++; $display("FAIL m15_neg got %b exp 1", b6.neg); end
    if (b6.tens_bcd !== 4'd1 || b6.ones_bcd !== 4'd5) begin n_fail++; $display("FAIL m15_bcd got %0d%0d exp 15", b6.tens_bcd, b6.ones_bcd); end
    if (b6.sign_seg !== 7'h3F) begin n_fail++; $display("FAIL m15_sign_seg got %h exp 3f", b6.sign_seg); end
    if (b6.tens_seg !== 7'h79) begin n_fail++; $display("FAIL m15_tens_seg got %h exp 79", b6.tens_seg); end
    if (b6.ones_seg !== 7'h12) begin n_fail++; $display("FAIL m15_ones_seg got %h exp 12", b6.ones_seg); end
    tick();
    n_checks++;
    if (b6.valid !== 1'b0) begin n_fail++; $display("FAIL m15_valid_pulse got %b exp 0", b6.valid); end
  endtask
  task automatic test_nine();
    int n;
    launch6(6'd9);
    wait_valid6(n);
    n_checks += 6;
    if (n !== 2) begin n_fail++; $display("FAIL p9_latency got %0d exp 2", n); end
    if (b6.neg !== 1'b0) begin n_fail++; $display("FAIL p9_neg got %b exp 0", b6.neg); end
    if (b6.tens_bcd !== 4'd0 || b6.ones_bcd !== 4'd9) begin n_fail++; $display("FAIL p9_bcd got %0d%0d exp 09", b6.tens_bcd, b6.ones_bcd); end
    if (b6.sign_seg !== 7'h7F) begin n_fail++; $display("FAIL p9_sign_seg got %h exp 7f", b6.sign_seg); end
    if (b6.tens_seg !== 7'h7F) begin n_fail++; $display("FAIL p9_tens_seg got %h exp 7f", b6.tens_seg); end
    if (b6.ones_seg !== 7'h10) begin n_fail++; $display("FAIL p9_ones_seg got %h exp 10", b6.ones_seg); end
  endtask
  task automatic test_extremes();
    int n;
    launch6(6'b100000);
    b6.data_in = 6'd17;
    wait_valid6(n);
    n_checks += 5;
    if (n !== 5) begin n_fail++; $display("FAIL m32_latency got %0d exp 5", n); end
    if (b6.neg !== 1'b1) begin n_fail++; $display("FAIL m32_neg got %b exp 1", b6.neg); end
    if (b6.tens_bcd !== 4'd3 || b6.ones_bcd !== 4'd2) begin n_fail++; $display("FAIL m32_bcd got %0d%0d exp 32", b6.tens_bcd, b6.ones_bcd); end
    if (b6.tens_seg !== 7'h30) begin n_fail++; $display("FAIL m32_tens_seg got %h exp 30", b6.tens_seg); end
    if (b6.ones_seg !== 7'h24) begin n_fail++; $display("FAIL m32_ones_seg got %h exp 24", b6.ones_seg); end
    launch6(6'd0);
    wait_valid6(n);
    n_checks += 6;
    if (n !== 2) begin n_fail++; $display("FAIL zero_latency got %0d exp 2", n); end
    if (b6.neg !== 1'b0) begin n_fail++; $display("FAIL zero_neg got %b exp 0", b6.neg); end
    if (b6.tens_bcd !== 4'd0 || b6.ones_bcd !== 4'd0) begin n_fail++; $display("FAIL zero_bcd got %0d%0d exp 00", b6.tens_bcd, b6.ones_bcd); end
    if (b6.sign_seg !== 7'h7F) begin n_fail++; $display("FAIL zero_sign_seg got %h exp 7f", b6.sign_seg); end
    if (b6.tens_seg !== 7'h7F) begin n_fail++; $display("FAIL zero_tens_seg got %h exp 7f", b6.tens_seg); end
    if (b6.ones_seg !== 7'h40) begin n_fail++; $display("FAIL zero_ones_seg got %h exp 40", b6.ones_seg); end
  endtask
  task automatic test_back_to_back();
    int n;
    launch6(6'b110001);
    b6.data_in = 6'd20;
    b6.start = 1'b1;
    wait_valid6(n);
    n_checks += 2;
    if (n !== 3) begin n_fail++; $display("FAIL b2b_latency got %0d exp 3", n); end
    if (b6.neg !== 1'b1 || b6.tens_bcd !== 4'd1 || b6.ones_bcd !== 4'd5) begin n_fail++; $display("FAIL b2b_result got neg=%b %0d%0d exp neg=1 15", b6.neg, b6.tens_bcd, b6.ones_bcd); end
    b6.data_in = 6'd9;
    tick();
    b6.start = 1'b0;
    n_checks += 3;
    if (b6.busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept_busy got %b exp 1", b6.busy); end
    if (b6.valid !== 1'b0) begin n_fail++; $display("FAIL b2b_single_valid got %b exp 0", b6.valid); end
    if (b6.ones_bcd !== 4'd5 || b6.ones_seg !== 7'h12) begin n_fail++; $display("FAIL b2b_hold got %0d/%h exp 5/12", b6.ones_bcd, b6.ones_seg); end
    wait_valid6(n);
    n_checks += 2;
    if (n !== 2) begin n_fail++; $display("FAIL b2b2_latency got %0d exp 2", n); end
    if (b6.neg !== 1'b0 || b6.ones_bcd !== 4'd9) begin n_fail++; $display("FAIL b2b2_result got neg=%b %0d exp neg=0 9", b6.neg, b6.ones_bcd); end
  endtask
  task automatic test_reset_mid();
    int seen = 0;
    launch6(6'd31);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks += 4;
    if (b6.busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy got %b exp 0", b6.busy); end
    if (b6.ones_bcd !== 4'd0) begin n_fail++; $display("FAIL rmid_ones got %0d exp 0", b6.ones_bcd); end
    if (b6.ones_seg !== 7'h7F) begin n_fail++; $display("FAIL rmid_ones_seg got %h exp 7f", b6.ones_seg); end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (b6.valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen !== 0) begin n_fail++; $display("FAIL rmid_no_valid got %0d exp 0", seen); end
    rst = 1'b1;
    b6.start = 1'b1;
    b6.data_in = 6'd9;
    tick();
    rst = 1'b0;
    b6.start = 1'b0;
    n_checks++;
    if (b6.busy !== 1'b0) begin n_fail++; $display("FAIL rst_start_busy got %b exp 0", b6.busy); end
  endtask
  task automatic test_width4();
    int n = -1;
    b4.data_in = 4'b1000;
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (b4.valid === 1'b1) begin n = k; break; end
    end
    n_checks += 6;
    if (n !== 2) begin n_fail++; $display("FAIL w4_latency got %0d exp 2", n); end
    if (b4.neg !== 1'b1) begin n_fail++; $display("FAIL w4_neg got %b exp 1", b4.neg); end
    if (b4.tens_bcd !== 4'd0 || b4.ones_bcd !== 4'd8) begin n_fail++; $display("FAIL w4_bcd got %0d%0d exp 08", b4.tens_bcd, b4.ones_bcd); end
    if (b4.sign_seg !== 7'h3F) begin n_fail++; $display("FAIL w4_sign_seg got %h exp 3f", b4.sign_seg); end
    if (b4.tens_seg !== 7'h7F) begin n_fail++; $display("FAIL w4_tens_seg got %h exp 7f", b4.tens_seg); end
    if (b4.ones_seg !== 7'h00) begin n_fail++; $display("FAIL w4_ones_seg got %h exp 00", b4.ones_seg); end
  endtask
  initial begin
    rst = 1'b1;
    b6.start = 1'b0;
    b6.data_in = '0;
    b4.start = 1'b0;
    b4.data_in = '0;
    tick();
    tick();
    test_reset();
    rst = 1'b0;
    tick();
    test_neg15();
    test_nine();
    test_extremes();
    test_back_to_back();
    test_reset_mid();
    test_width4();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
